serial_sub: RTL and testbench
=============================

# serial_sub

Bit-serial signed subtractor computing `diff = a - b` as `a + ~b + 1`, one bit per clock, LSB first, with a start/busy/done handshake. It is the sequential counterpart to the combinational 6-bit adder datapath. It serves area-constrained paths where WIDTH-cycle latency is acceptable. It reports two's-complement overflow with the same meaning as the adder's `overflow` flag.

## Interface
- `WIDTH`, 6: operand and result width (two's complement, ≥2).
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `start` input 1: request; sampled on rising edge.
- `a` input WIDTH: signed minuend; sampled with accepted `start`.
- `b` input WIDTH: signed subtrahend; sampled with accepted `start`.
- `busy` output 1: high while bits are being shifted.
- `done` output 1: one-cycle pulse; `diff`/`overflow` updated this cycle.
- `diff` output WIDTH: signed result register.
- `overflow` output 1: true difference outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: `start`=1 → latch `a` into shift reg A and `~b` into shift reg B, carry←1, bit counter←0, → SHIFT.
- SHIFT: each cycle, full-add A[0], B[0], carry. Shift the sum bit into the result shift reg from the MSB side. Shift A and B right. Counter+1.
  - Record carry into the MSB (before the last bit) and carry out of the MSB.
  - After bit WIDTH-1 → DONE.
- DONE: `diff` ← result shift reg; `overflow` ← carry_in_msb XOR carry_out_msb; `done`=1.
  - `start`=1 in DONE → accepted exactly as from IDLE (back-to-back), → SHIFT.
  - Otherwise → IDLE.
- `start` while in SHIFT: ignored, no queueing; operands not re-sampled.
- `diff`/`overflow` are written only on entry to DONE; they hold until the next DONE.
- Internal shift registers are never visible on outputs.
- `rst` asserted at any time: state IDLE, `busy`=0, `done`=0, `diff`=0, `overflow`=0, counter 0, carry 0. Any in-flight operation is aborted with no `done`.

## Timing
- Start accepted at edge of cycle 0 → `busy`=1 cycles 1..WIDTH → `done`=1 and new `diff`/`overflow` in cycle WIDTH+1.
- Latency WIDTH+1 cycles start-to-done (7 for WIDTH=6).
- Throughput: one result per WIDTH+1 cycles with back-to-back `start`.
- `busy` and `done` are never high together. `busy`=0 in IDLE and DONE.
- All outputs registered; no combinational path from inputs to outputs.
- Reset values: `busy`=0, `done`=0, `diff`=0, `overflow`=0.

## Configuration
- Macro `SERIAL_SUB_SAT_EN`.
  - Defined: on overflow, `diff` saturates. If minuend sign=1, `diff` = -2^(WIDTH-1) (-32); if sign=0, `diff` = 2^(WIDTH-1)-1 (31). `overflow` is still reported as 1.
  - Undefined: `diff` is the wrapped WIDTH-bit result.
- No effect on latency or handshake.

## Structure
- Package `serial_sub_pkg`:
  - FSM state typedef (IDLE/SHIFT/DONE).
  - Default WIDTH constant.
  - Functions returning saturation min/max for a given width.
- Sub-module `full_adder_bit`: 1-bit combinational full adder (a, b, cin → s, cout), instantiated once for the serial datapath.
- Counter width: $clog2(WIDTH).

## Test plan
- `a`=5, `b`=3, `start` one cycle → `busy` cycles 1–6, `done` cycle 7, `diff`=2, `overflow`=0.
- `a`=-32, `b`=1 → `overflow`=1; `diff`=31 without macro, -32 with `SERIAL_SUB_SAT_EN`.
- `a`=31, `b`=-1 → `overflow`=1; `diff`=-32 without macro, 31 with macro. Also `a`=-32, `b`=-32 → `diff`=0, `overflow`=0.
- `start` held high continuously with operand pairs (7,-2) then (-5,4) → `done` at cycles 7 and 14, results 9 and -9. `start` pulses during SHIFT are ignored.
- `rst` asserted in cycle 3 of an operation → all outputs 0 immediately. No `done` follows. A new `start` after reset release completes normally.
- Exhaustive sweep of all 64×64 operand pairs against an integer model → every `diff`/`overflow` matches, `done` exactly once per start.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared types and constants for the bit-serial subtractor
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 6;

    function automatic int sat_min(input int w);
        return -(1 << (w - 1));
    endfunction

    function automatic int sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

endpackage

// File: rtl/serial_sub_if.sv
// rtl/serial_sub_if.sv - start/busy/done operand and result bundle of serial_sub
interface serial_sub_if import serial_sub_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             overflow;

    modport master (output start, a, b, input busy, done, diff, overflow);
    modport slave  (input start, a, b, output busy, done, diff, overflow);
endinterface

// File: rtl/serial_sub_full_adder_bit.sv
// rtl/serial_sub_full_adder_bit.sv - 1-bit combinational full adder for the serial datapath
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial signed subtractor diff = a + ~b + 1, LSB first
// SERIAL_SUB_SAT_EN: saturate diff on overflow instead of wrapping.
module serial_sub import serial_sub_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic      clk,
    input  logic      rst,
    serial_sub_if.slave bus
);
    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-2:0] res_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             ovf_q;

    logic             sum_d;
    logic             cout_d;
    logic             ovf_d;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] diff_d;

    full_adder_bit u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .s    (sum_d),
        .cout (cout_d)
    );

    // On the last bit, carry_q is the carry into the MSB and a_sh_q[0] is the minuend sign.
    always_comb begin
        res_d  = {sum_d, res_q};
        ovf_d  = carry_q ^ cout_d;
        diff_d = res_d;
`ifdef SERIAL_SUB_SAT_EN
        if (ovf_d) begin
            diff_d = a_sh_q[0] ? WIDTH'(sat_min(WIDTH)) : WIDTH'(sat_max(WIDTH));
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_sh_q  <= bus.a;
                        b_sh_q  <= ~bus.b;
                        carry_q <= 1'b1;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    a_sh_q  <= a_sh_q >> 1;
                    b_sh_q  <= b_sh_q >> 1;
                    res_q   <= res_d[WIDTH-1:1];
                    carry_q <= cout_d;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        diff_q  <= diff_d;
                        ovf_q   <= ovf_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.diff     = diff_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_serial_sub.sv
// tb/tb_serial_sub.sv - scoreboard bench for serial_sub (directed vectors plus full sweep)
module tb_serial_sub;
    localparam int W = 6;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         ovf;
    } exp_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   n_done;
    int   n_issued;
    exp_t exp_q[$];

    serial_sub_if #(.WIDTH(W)) bus ();

    serial_sub #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [W-1:0] d, input logic o);
        exp_t e;
        e.diff = d;
        e.ovf  = o;
        exp_q.push_back(e);
        n_issued++;
    endtask

    function automatic exp_t model(input int x, input int y);
        exp_t e;
        int   d;
        d      = x - y;
        e.ovf  = (d > (1 << (W - 1)) - 1) || (d < -(1 << (W - 1)));
        e.diff = W'(d);
`ifdef SERIAL_SUB_SAT_EN
        if (e.ovf) e.diff = (x < 0) ? W'(-(1 << (W - 1))) : W'((1 << (W - 1)) - 1);
`endif
        return e;
    endfunction

    // Monitor: every done pulse consumes exactly one expected result.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            exp_t e;
            n_done++;
            chk("busy_with_done", int'(bus.busy), 0);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done with empty scoreboard, required none");
            end else begin
                e = exp_q.pop_front();
                chk("diff", int'($signed(bus.diff)), int'($signed(e.diff)));
                chk("overflow", int'(bus.overflow), int'(e.ovf));
            end
        end
    end

    task automatic wait_done();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done) return;
        end
        chk("done_timeout", 0, 1);
    endtask

    task automatic run_op(input int x, input int y, input exp_t e);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = W'(x);
        bus.b     = W'(y);
        push_exp(e.diff, e.ovf);
        @(negedge clk);
        bus.start = 1'b0;
        if (!bus.done) wait_done();
    endtask

    initial begin
        exp_t e;
        int   done_before;
        n_tests  = 0;
        n_fail   = 0;
        n_done   = 0;
        n_issued = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_diff", int'(bus.diff), 0);
        chk("rst_ovf", int'(bus.overflow), 0);
        rst = 1'b0;

        // 5 - 3: exact busy/done timing
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 6'd5;
        bus.b     = 6'd3;
        push_exp(6'd2, 1'b0);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
            chk($sformatf("t1_busy_c%0d", c), int'(bus.busy), (c <= 6) ? 1 : 0);
            chk($sformatf("t1_done_c%0d", c), int'(bus.done), (c == 7) ? 1 : 0);
        end

`ifdef SERIAL_SUB_SAT_EN
        e.diff = 6'b100000; e.ovf = 1'b1; run_op(-32, 1, e);
        e.diff = 6'b011111; e.ovf = 1'b1; run_op(31, -1, e);
`else
        e.diff = 6'b011111; e.ovf = 1'b1; run_op(-32, 1, e);
        e.diff = 6'b100000; e.ovf = 1'b1; run_op(31, -1, e);
`endif
        e.diff = 6'd0; e.ovf = 1'b0; run_op(-32, -32, e);

        // start held high: second op accepted straight out of DONE, SHIFT-time operands ignored
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 6'd7;
        bus.b     = 6'b111110;
        push_exp(6'd9, 1'b0);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 7) begin
                bus.a = 6'b111011;
                bus.b = 6'd4;
                push_exp(6'b110111, 1'b0);
            end else if (c == 14) begin
                bus.start = 1'b0;
            end else begin
                bus.a = 6'd13;
                bus.b = 6'd13;
            end
            chk($sformatf("b2b_done_c%0d", c), int'(bus.done), (c == 7 || c == 14) ? 1 : 0);
        end

        // reset in cycle 3 aborts the operation with no done
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 6'd10;
        bus.b     = 6'd3;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_done", int'(bus.done), 0);
        chk("abort_diff", int'(bus.diff), 0);
        chk("abort_ovf", int'(bus.overflow), 0);
        @(negedge clk);
        rst = 1'b0;
        done_before = n_done;
        repeat (12) @(negedge clk);
        chk("abort_no_done", n_done, done_before);
        e.diff = 6'd13; e.ovf = 1'b0; run_op(9, -4, e);

        for (int x = -32; x < 32; x++) begin
            for (int y = -32; y < 32; y++) begin
                run_op(x, y, model(x, y));
            end
        end

        @(negedge clk);
        chk("done_per_start", n_done, n_issued);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
